// File: rtl/robs_control_unit.sv
// Sequencing FSM for the signed Robertson multiplier datapath: issues the
// 15-bit control word per state and tracks iterations to pick the final subtract.
module robs_control_unit #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        zr,
    input  logic        zq,
    output logic [14:0] c,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int STEP_W = $clog2(WIDTH) + 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);
    localparam logic [STEP_W-1:0] MAX_STEP  = STEP_W'(WIDTH);

    // Control word bit positions
    localparam int C_LOAD_Y    = 0;
    localparam int C_CNT_LOAD  = 1;
    localparam int C_CLR_A     = 2;
    localparam int C_LOAD_X    = 3;
    localparam int C_RH_MUX_LO = 4;
    localparam int C_RH_MUX_HI = 5;
    localparam int C_RL_MUX    = 6;
    localparam int C_X_MUX     = 7;
    localparam int C_LOAD_RH   = 8;
    localparam int C_LOAD_RL   = 9;
    localparam int C_ADD_SUB   = 10;
    localparam int C_SR_SHIFT  = 11;
    localparam int C_SR_LOAD   = 12;
    localparam int C_CNT_DEC   = 13;
    localparam int C_LOAD_A    = 14;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_XFER, S_TEST, S_ADD, S_ADD_WB,
        S_SHIFT_LD, S_SHIFT, S_SHIFT_WB, S_CHECK, S_FINAL, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              err_q, err_d;
    logic              add_not_sub;

    // The last iteration weights the sign bit, so it subtracts instead of adds.
    assign add_not_sub = (step_q != LAST_STEP);
    assign err         = err_q;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        err_d   = err_q;
        c       = '0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_LOAD;
                    step_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                c[C_LOAD_Y]   = 1'b1;
                c[C_CNT_LOAD] = 1'b1;
                c[C_CLR_A]    = 1'b1;
                c[C_LOAD_X]   = 1'b1;
                state_d       = S_XFER;
            end
            S_XFER: begin
                c[C_LOAD_RH] = 1'b1;
                c[C_LOAD_RL] = 1'b1;
                state_d      = S_TEST;
            end
            S_TEST: state_d = zr ? S_SHIFT_LD : S_ADD;
            S_ADD: begin
                c[C_ADD_SUB] = add_not_sub;
                state_d      = S_ADD_WB;
            end
            S_ADD_WB: begin
                c[C_ADD_SUB]   = add_not_sub;
                c[C_LOAD_RH]   = 1'b1;
                c[C_RH_MUX_HI] = 1'b1;
                state_d        = S_SHIFT_LD;
            end
            S_SHIFT_LD: begin
                c[C_SR_LOAD] = 1'b1;
                state_d      = S_SHIFT;
            end
            S_SHIFT: begin
                c[C_SR_SHIFT] = 1'b1;
                state_d       = S_SHIFT_WB;
            end
            S_SHIFT_WB: begin
                c[C_LOAD_RH]   = 1'b1;
                c[C_LOAD_RL]   = 1'b1;
                c[C_RH_MUX_LO] = 1'b1;
                c[C_RL_MUX]    = 1'b1;
                c[C_CNT_DEC]   = 1'b1;
                if (step_q != MAX_STEP) step_d = step_q + 1'b1;
                state_d        = S_CHECK;
            end
            S_CHECK: begin
                // A terminal count wins even when the iteration limit is reached.
                if (zq) begin
                    state_d = S_FINAL;
                end else if (step_q == MAX_STEP) begin
                    err_d   = 1'b1;
                    state_d = S_FINAL;
                end else begin
                    state_d = S_TEST;
                end
            end
            S_FINAL: begin
                c[C_LOAD_A] = 1'b1;
                c[C_LOAD_X] = 1'b1;
                c[C_X_MUX]  = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_robs_control_unit.sv
// Bench for robs_control_unit: a behavioural datapath closes the loop, and
// products, latencies and handshake are checked against arithmetic expectations.
module tb_robs_control_unit;
    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        zr, zq;
    logic [14:0] c;
    logic        busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    robs_control_unit #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .zr   (zr),
        .zq   (zq),
        .c    (c),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    // Behavioural datapath; R high is one bit wider so adds never overflow.
    logic [7:0]  mplier = '0, mcand = '0;
    logic [8:0]  y_r = '0, a_r = '0, alu_r = '0;
    logic [7:0]  x_r = '0;
    logic [16:0] r_r = '0, sr_r = '0;
    logic [3:0]  q_r = '0;
    logic        zq_force = 1'b0, zq_val = 1'b0;

    assign zr = ~r_r[0];
    assign zq = zq_force ? zq_val : (q_r[2:0] == 3'd0);

    always @(posedge clk) begin
        if (c[0]) y_r <= {mcand[7], mcand};
        if (c[1]) q_r <= 4'd8;
        else if (c[13]) q_r <= q_r - 4'd1;
        if (c[2]) a_r <= '0;
        else if (c[14]) a_r <= r_r[16:8];
        if (c[3]) x_r <= c[7] ? r_r[7:0] : mplier;
        alu_r <= c[10] ? (r_r[16:8] + y_r) : (r_r[16:8] - y_r);
        if (c[8]) begin
            case (c[5:4])
                2'b00:   r_r[16:8] <= a_r;
                2'b01:   r_r[16:8] <= sr_r[16:8];
                default: r_r[16:8] <= alu_r;
            endcase
        end
        if (c[9]) r_r[7:0] <= c[6] ? sr_r[7:0] : x_r;
        if (c[12]) sr_r <= r_r;
        else if (c[11]) sr_r <= {sr_r[16], sr_r[16:1]};
    end

    function automatic int lat(input logic [7:0] mp);
        return 4 + 5 * WIDTH + 2 * $countones(mp);
    endfunction

    // One full multiply: start pulse, then per-cycle observation up to done.
    task automatic run_op(input string name, input logic [7:0] mp, input logic [7:0] mc,
                          input int exp_done, input int exp_adds, input bit exp_err,
                          input bit chk_prod);
        int          done_at, adds, shifts, busy_bad, c10_bad;
        logic        exp_c10;
        logic [15:0] exp_prod, got_prod;
        done_at = 0; adds = 0; shifts = 0; busy_bad = 0; c10_bad = 0;
        mplier = mp; mcand = mc;
        exp_prod = 16'($signed(mp) * $signed(mc));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 300 && done_at == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                n_tests++;
                if (err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s err_after_start: got %b expected 0", name, err);
                end
            end
            if (busy !== 1'b1) busy_bad++;
            if (c[8] && c[5:4] == 2'b10) begin
                exp_c10 = (shifts != WIDTH - 1);
                if (c[10] !== exp_c10) c10_bad++;
                adds++;
            end
            if (c[13]) shifts++;
            if (done === 1'b1) done_at = n;
        end
        got_prod = {a_r[7:0], x_r};
        n_tests++;
        if (done_at != exp_done) begin
            n_fail++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_at, exp_done);
        end
        n_tests++;
        if (adds != exp_adds || c10_bad != 0) begin
            n_fail++;
            $display("FAIL %s add_steps: got %0d adds (%0d bad c10) expected %0d adds", name, adds, c10_bad, exp_adds);
        end
        n_tests++;
        if (busy_bad != 0 || err !== exp_err) begin
            n_fail++;
            $display("FAIL %s busy_err: busy low %0d cycles, err %b expected %b", name, busy_bad, err, exp_err);
        end
        if (chk_prod) begin
            n_tests++;
            if (got_prod !== exp_prod) begin
                n_fail++;
                $display("FAIL %s product: got %h expected %h", name, got_prod, exp_prod);
            end
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || c !== 15'd0 || err !== exp_err) begin
            n_fail++;
            $display("FAIL %s idle_after: busy %b done %b c %h err %b expected 0 0 0000 %b", name, busy, done, c, err, exp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_tests++;
            if (c !== 15'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: c %h busy %b done %b err %b expected all 0", c, busy, done, err);
            end
        end
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || c !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_release: busy %b c %h expected 0 0000", busy, c);
        end
    endtask

    task automatic test_directed();
        run_op("zero_mult", 8'h00, 8'h37, 44, 0, 1'b0, 1'b1);
        run_op("positive",  8'h05, 8'h03, 48, 2, 1'b0, 1'b1);
        run_op("negative",  8'hFD, 8'h05, 58, 7, 1'b0, 1'b1);
        run_op("extremes",  8'h80, 8'h80, lat(8'h80), 1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] mp, mc;
        for (int i = 0; i < 16; i++) begin
            mp = 8'($urandom_range(0, 255));
            mc = 8'($urandom_range(0, 255));
            run_op("random", mp, mc, lat(mp), $countones(mp), 1'b0, 1'b1);
        end
    endtask

    // start held high throughout: no restart while busy, one idle cycle between ops.
    task automatic test_back_to_back();
        int d1, pulses, first_at, second_at, limit;
        mplier = 8'h6B; mcand = 8'hC4;
        d1 = lat(8'h6B);
        limit = 2 * d1 + 1;
        pulses = 0; first_at = 0; second_at = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                if (pulses == 1) first_at = n;
                if (pulses == 2) second_at = n;
            end
            if (n == limit) start = 1'b0;
        end
        n_tests++;
        if (pulses != 2 || first_at != d1 || second_at != limit) begin
            n_fail++;
            $display("FAIL back_to_back: %0d pulses at %0d,%0d expected 2 at %0d,%0d", pulses, first_at, second_at, d1, limit);
        end
        n_tests++;
        if ({a_r[7:0], x_r} !== 16'($signed(8'h6B) * $signed(8'hC4))) begin
            n_fail++;
            $display("FAIL back_to_back product: got %h", {a_r[7:0], x_r});
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back settle: busy %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        mplier = 8'hFF; mcand = 8'h11;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        n_tests++;
        if (c !== 15'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: c %h busy %b done %b err %b expected all 0", c, busy, done, err);
        end
        run_op("after_reset", 8'hFF, 8'h11, lat(8'hFF), 8, 1'b0, 1'b1);
    endtask

    task automatic test_missing_zq();
        logic [7:0] mp;
        mp = 8'($urandom_range(0, 255));
        zq_force = 1'b1;
        zq_val   = 1'b0;
        run_op("missing_zq", mp, 8'h9A, lat(mp), $countones(mp), 1'b1, 1'b1);
        zq_force = 1'b0;
        run_op("err_clear", 8'h33, 8'h21, lat(8'h33), 4, 1'b0, 1'b1);
    endtask

    // Terminal count seen after the first iteration ends the multiply early.
    task automatic test_early_zq();
        zq_force = 1'b1;
        zq_val   = 1'b1;
        run_op("early_zq_even", 8'h42, 8'h13, 9, 0, 1'b0, 1'b0);
        run_op("early_zq_odd",  8'h43, 8'h13, 11, 1, 1'b0, 1'b0);
        zq_force = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_missing_zq();
        test_early_zq();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
